// File: rtl/al_map_pkg.sv
// Shared encodings and parameter decoding for the al_map arithmetic cells.
package al_map_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'd0,
        ALU_SUB    = 2'd1,
        ALU_UPDOWN = 2'd2
    } alu_e;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_e;

    // String parameters arrive as packed characters, zero-extended to 64 bits.
    function automatic alu_e alu_decode(input logic [63:0] s);
        if (s == 64'("SUB"))
            return ALU_SUB;
        else if (s == 64'("UPDOWN"))
            return ALU_UPDOWN;
        return ALU_ADD;
    endfunction

    function automatic ovf_e ovf_decode(input logic [63:0] s);
        return (s == 64'("SAT")) ? OVF_SAT : OVF_WRAP;
    endfunction

    function automatic logic regset_is_set(input logic [63:0] s);
        return (s == 64'("SET"));
    endfunction

endpackage

// File: rtl/al_map_addsub.sv
// Combinational WIDTH-bit add/subtract with carry/borrow on r[WIDTH].
module al_map_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH:0]   r
);

    localparam int unsigned RW = WIDTH + 1;

    // Subtract in WIDTH+1 bits so a negative result sets the borrow bit.
    always_comb begin
        if (sub)
            r = RW'(a) - RW'(b) - RW'(cin);
        else
            r = RW'(a) + RW'(b) + RW'(cin);
    end

endmodule

// File: rtl/al_map_accum.sv
// Registered carry-chain accumulator/counter with load, wrap/saturate,
// sticky overflow and terminal-count compare.
module al_map_accum
    import al_map_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter              ALUTYPE = "ADD",
    parameter              REGSET  = "RESET",
    parameter              OVFMODE = "WRAP",
    parameter logic [31:0] TCVAL   = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             sr,
    input  logic             ce,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf,
    output logic             tc
);

    localparam alu_e             ALU     = alu_decode(64'(ALUTYPE));
    localparam ovf_e             OVF     = ovf_decode(64'(OVFMODE));
    localparam logic [WIDTH-1:0] RST_VAL = regset_is_set(64'(REGSET)) ? '1 : '0;
    localparam logic [WIDTH-1:0] TC_CMP  = TCVAL[WIDTH-1:0];

    logic             sub_op;
    logic [WIDTH:0]   r;
    logic             c;
    logic [WIDTH-1:0] q_nxt;

    assign sub_op = (ALU == ALU_SUB) || ((ALU == ALU_UPDOWN) && dir);

    al_map_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (q),
        .b   (b),
        .cin (cin),
        .sub (sub_op),
        .r   (r)
    );

    assign c = r[WIDTH];

    // Saturation clamps toward the rail the operation was heading for.
    always_comb begin
        q_nxt = r[WIDTH-1:0];
        if ((OVF == OVF_SAT) && c)
            q_nxt = sub_op ? '0 : '1;
    end

    always_ff @(posedge clk or posedge sr) begin
        if (sr) begin
            q    <= RST_VAL;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (ce) begin
            if (ld) begin
                q    <= ld_val;
                cout <= 1'b0;
                ovf  <= 1'b0;
            end else begin
                q    <= q_nxt;
                cout <= c;
                ovf  <= ovf | c;
            end
        end
    end

    assign tc = (q == TC_CMP);

endmodule

// File: tb/tb_al_map_accum.sv
// Directed self-checking bench for al_map_accum across several configurations.
module tb_al_map_accum;

    logic clk = 1'b0;
    logic sr, ce, ld, cin, dir;
    logic [7:0]  ldv8, b8;
    logic [3:0]  ldv4, b4;
    logic [0:0]  ldv1, b1;
    logic [31:0] ldv32, b32;

    logic [7:0]  q_a8, q_s8;
    logic [3:0]  q_ud;
    logic [0:0]  q_w1;
    logic [31:0] q_ww, q_ws;
    logic c_a8, o_a8, t_a8, c_s8, o_s8, t_s8, c_ud, o_ud, t_ud;
    logic c_w1, o_w1, t_w1, c_ww, o_ww, t_ww, c_ws, o_ws, t_ws;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    al_map_accum #(.WIDTH(8), .ALUTYPE("ADD"), .REGSET("SET"), .OVFMODE("WRAP")) u_add8 (
        .clk(clk), .sr(sr), .ce(ce), .ld(ld), .ld_val(ldv8), .b(b8), .cin(cin), .dir(dir),
        .q(q_a8), .cout(c_a8), .ovf(o_a8), .tc(t_a8));

    al_map_accum #(.WIDTH(8), .ALUTYPE("SUB"), .OVFMODE("SAT")) u_sub8 (
        .clk(clk), .sr(sr), .ce(ce), .ld(ld), .ld_val(ldv8), .b(b8), .cin(cin), .dir(dir),
        .q(q_s8), .cout(c_s8), .ovf(o_s8), .tc(t_s8));

    al_map_accum #(.WIDTH(4), .ALUTYPE("UPDOWN")) u_ud4 (
        .clk(clk), .sr(sr), .ce(ce), .ld(ld), .ld_val(ldv4), .b(b4), .cin(cin), .dir(dir),
        .q(q_ud), .cout(c_ud), .ovf(o_ud), .tc(t_ud));

    al_map_accum #(.WIDTH(1), .ALUTYPE("ADD")) u_w1 (
        .clk(clk), .sr(sr), .ce(ce), .ld(ld), .ld_val(ldv1), .b(b1), .cin(cin), .dir(dir),
        .q(q_w1), .cout(c_w1), .ovf(o_w1), .tc(t_w1));

    al_map_accum #(.WIDTH(32), .ALUTYPE("ADD"), .OVFMODE("WRAP")) u_w32w (
        .clk(clk), .sr(sr), .ce(ce), .ld(ld), .ld_val(ldv32), .b(b32), .cin(cin), .dir(dir),
        .q(q_ww), .cout(c_ww), .ovf(o_ww), .tc(t_ww));

    al_map_accum #(.WIDTH(32), .ALUTYPE("ADD"), .OVFMODE("SAT")) u_w32s (
        .clk(clk), .sr(sr), .ce(ce), .ld(ld), .ld_val(ldv32), .b(b32), .cin(cin), .dir(dir),
        .q(q_ws), .cout(c_ws), .ovf(o_ws), .tc(t_ws));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sr = 1'b1; ce = 1'b0; ld = 1'b0; cin = 1'b0; dir = 1'b0;
        ldv8 = '0; b8 = '0; ldv4 = '0; b4 = '0; ldv1 = '0; b1 = '0; ldv32 = '0; b32 = '0;
        #12;
        check_val("rst_q_set",   32'(q_a8), 32'h0000_00FF);
        check_val("rst_tc_set",  32'(t_a8), 32'h1);
        check_val("rst_cout",    32'(c_a8), 32'h0);
        check_val("rst_ovf",     32'(o_a8), 32'h0);
        check_val("rst_q_reset", 32'(q_s8), 32'h0);
        sr = 1'b0;

        // Increment through FF -> 00
        ce = 1'b1; ld = 1'b1; ldv8 = 8'hFD; b8 = 8'h00; cin = 1'b1;
        step();
        check_val("inc_ld_q",   32'(q_a8), 32'hFD);
        ld = 1'b0;
        step();
        check_val("inc_fe_q",   32'(q_a8), 32'hFE);
        check_val("inc_fe_tc",  32'(t_a8), 32'h0);
        step();
        check_val("inc_ff_q",   32'(q_a8), 32'hFF);
        check_val("inc_ff_tc",  32'(t_a8), 32'h1);
        check_val("inc_ff_cout",32'(c_a8), 32'h0);
        step();
        check_val("inc_00_q",   32'(q_a8), 32'h00);
        check_val("inc_00_tc",  32'(t_a8), 32'h0);
        check_val("inc_00_cout",32'(c_a8), 32'h1);
        check_val("inc_00_ovf", 32'(o_a8), 32'h1);
        step();
        check_val("inc_01_q",   32'(q_a8), 32'h01);
        check_val("inc_01_cout",32'(c_a8), 32'h0);
        check_val("inc_01_ovf", 32'(o_a8), 32'h1);

        // Asynchronous reset in the middle of a cycle
        ld = 1'b1; ldv8 = 8'h12;
        step();
        check_val("mid_ld_q",   32'(q_a8), 32'h12);
        ld = 1'b0; b8 = 8'hF0; cin = 1'b0;
        step();
        check_val("mid_add_q",  32'(q_a8), 32'h02);
        check_val("mid_add_ovf",32'(o_a8), 32'h1);
        b8 = 8'h00; cin = 1'b1;
        #2 sr = 1'b1;
        #1;
        check_val("async_q",    32'(q_a8), 32'hFF);
        check_val("async_cout", 32'(c_a8), 32'h0);
        check_val("async_ovf",  32'(o_a8), 32'h0);
        #3 sr = 1'b0;
        step();
        check_val("post_rst_q",    32'(q_a8), 32'h00);
        check_val("post_rst_cout", 32'(c_a8), 32'h1);

        // Saturating subtract
        ld = 1'b1; ldv8 = 8'h05;
        step();
        ld = 1'b0; b8 = 8'h07; cin = 1'b0;
        step();
        check_val("sat_q",      32'(q_s8), 32'h00);
        check_val("sat_cout",   32'(c_s8), 32'h1);
        check_val("sat_ovf",    32'(o_s8), 32'h1);
        b8 = 8'h00;
        step();
        check_val("sat2_q",     32'(q_s8), 32'h00);
        check_val("sat2_cout",  32'(c_s8), 32'h0);
        check_val("sat2_ovf",   32'(o_s8), 32'h1);

        // Clock enable gates load; load beats an overflowing add
        ld = 1'b1; ldv8 = 8'hF0;
        step();
        ld = 1'b0; b8 = 8'h20;
        step();
        check_val("ce_pre_q",   32'(q_a8), 32'h10);
        check_val("ce_pre_ovf", 32'(o_a8), 32'h1);
        ce = 1'b0; ld = 1'b1; ldv8 = 8'hAA;
        step();
        check_val("ce0_q",      32'(q_a8), 32'h10);
        check_val("ce0_ovf",    32'(o_a8), 32'h1);
        check_val("ce0_cout",   32'(c_a8), 32'h1);
        ce = 1'b1; b8 = 8'hFF; cin = 1'b1;
        step();
        check_val("ldpri_q",    32'(q_a8), 32'hAA);
        check_val("ldpri_cout", 32'(c_a8), 32'h0);
        check_val("ldpri_ovf",  32'(o_a8), 32'h0);

        // Up/down on a 4-bit instance
        ld = 1'b1; ldv4 = 4'h7;
        step();
        ld = 1'b0; b4 = 4'h3; cin = 1'b0; dir = 1'b0;
        step();
        check_val("ud_up_q",    32'(q_ud), 32'hA);
        dir = 1'b1;
        step();
        check_val("ud_dn_q",    32'(q_ud), 32'h7);
        b4 = 4'h8;
        step();
        check_val("ud_wrap_q",  32'(q_ud), 32'hF);
        check_val("ud_wrap_c",  32'(c_ud), 32'h1);
        dir = 1'b0;

        // Single-bit toggle
        ld = 1'b1; ldv1 = 1'b0;
        step();
        ld = 1'b0; b1 = 1'b0; cin = 1'b1;
        step();
        check_val("w1_q1",      32'(q_w1), 32'h1);
        check_val("w1_c1",      32'(c_w1), 32'h0);
        check_val("w1_tc1",     32'(t_w1), 32'h1);
        step();
        check_val("w1_q0",      32'(q_w1), 32'h0);
        check_val("w1_c0",      32'(c_w1), 32'h1);
        step();
        check_val("w1_q1b",     32'(q_w1), 32'h1);
        check_val("w1_c1b",     32'(c_w1), 32'h0);

        // 32-bit overflow: wrap versus saturate
        ld = 1'b1; ldv32 = 32'hFFFF_FFFF;
        step();
        ld = 1'b0; b32 = 32'h1; cin = 1'b0;
        step();
        check_val("w32_wrap_q", q_ww, 32'h0);
        check_val("w32_wrap_c", 32'(c_ww), 32'h1);
        check_val("w32_sat_q",  q_ws, 32'hFFFF_FFFF);
        check_val("w32_sat_c",  32'(c_ws), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
